// File: rtl/alarm_set_pkg.sv
// Shared encodings and BCD limits for the alarm-time writer.
// The button edge helper is reused by every button in alarm_set.
package alarm_set_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EDIT   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    localparam logic F_HOUR = 1'b0;
    localparam logic F_MIN  = 1'b1;

    localparam logic [7:0] HOUR_MAX = 8'h23;
    localparam logic [7:0] MIN_MAX  = 8'h59;

    function automatic logic rose(input logic now, input logic prev);
        return now & ~prev;
    endfunction

endpackage

// File: rtl/alarm_set_step.sv
// Combinational BCD field stepper: +1/-1 on one HH or MM field with range wrap.
// Works digit by digit; out-of-range inputs snap to 00 (up) or the maximum (down).
module alarm_set_step
    import alarm_set_pkg::*;
(
    input  logic [7:0] value,
    input  logic       up,
    input  logic       down,
    input  logic       is_hour,
    output logic [7:0] next
);

    logic [7:0] max_s;

    // Per-digit increment/decrement; up and down together leave the field alone
    always_comb begin
        max_s = is_hour ? HOUR_MAX : MIN_MAX;
        next  = value;
        if (up && !down) begin
            if (value >= max_s) begin
                next = 8'h00;
            end else if (value[3:0] >= 4'h9) begin
                next = {value[7:4] + 4'h1, 4'h0};
            end else begin
                next = {value[7:4], value[3:0] + 4'h1};
            end
        end else if (down && !up) begin
            if ((value == 8'h00) || (value > max_s)) begin
                next = max_s;
            end else if (value[3:0] == 4'h0) begin
                next = {value[7:4] - 4'h1, 4'h9};
            end else begin
                next = {value[7:4], value[3:0] - 4'h1};
            end
        end else begin
            next = value;
        end
    end

endmodule

// File: rtl/alarm_set.sv
// Alarm-time writer: edit a shadow HH:MM with buttons, publish it to alarm on commit.
// Buttons are edge-detected; up/down auto-repeat after a hold delay.
module alarm_set
    import alarm_set_pkg::*;
#(
    parameter logic [15:0] ALARM_INIT   = 16'h0000,
    parameter int          REPEAT_DELAY = 500,
    parameter int          REPEAT_RATE  = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        SPDT_set,
    input  logic        push_u,
    input  logic        push_d,
    input  logic        push_l,
    input  logic        push_r,
    input  logic        push_c,
    output logic [15:0] alarm,
    output logic [15:0] edit_value,
    output logic        edit_field,
    output logic        editing,
    output logic        alarm_changed
);

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CNT_W   = $clog2(CNT_MAX + 2);
    localparam logic [CNT_W-1:0] DELAY_C  = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RATE_C   = CNT_W'(REPEAT_RATE);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    logic [15:0]      alarm_r;
    logic [15:0]      shadow_r;
    logic             field_r;
    logic             editing_r;
    logic             changed_r;
    logic             u_hist_r;
    logic             d_hist_r;
    logic             l_hist_r;
    logic             r_hist_r;
    logic             c_hist_r;
    logic [CNT_W-1:0] rep_cnt_r;
    logic             rep_on_r;

    logic       u_only_s;
    logic       d_only_s;
    logic       u_rise_s;
    logic       d_rise_s;
    logic       l_rise_s;
    logic       r_rise_s;
    logic       c_rise_s;
    logic       field_evt_s;
    logic       act_rise_s;
    logic       rep_fire_s;
    logic       step_up_s;
    logic       step_dn_s;
    logic [7:0] field_val_s;
    logic [7:0] field_next_s;

    // Button edges, repeat timing and the step request for this cycle
    always_comb begin
        u_only_s    = push_u & ~push_d;
        d_only_s    = push_d & ~push_u;
        u_rise_s    = rose(push_u, u_hist_r);
        d_rise_s    = rose(push_d, d_hist_r);
        l_rise_s    = rose(push_l, l_hist_r);
        r_rise_s    = rose(push_r, r_hist_r);
        c_rise_s    = rose(push_c, c_hist_r);
        field_evt_s = l_rise_s ^ r_rise_s;
        act_rise_s  = (u_only_s & u_rise_s) | (d_only_s & d_rise_s);
        // A zero counter means no armed press, so a button held across edit entry stays silent
        if (rep_cnt_r == CNT_ZERO) begin
            rep_fire_s = 1'b0;
        end else if (rep_on_r) begin
            rep_fire_s = (rep_cnt_r == RATE_C);
        end else begin
            rep_fire_s = (rep_cnt_r == DELAY_C);
        end
        step_up_s   = u_only_s & (u_rise_s | rep_fire_s);
        step_dn_s   = d_only_s & (d_rise_s | rep_fire_s);
        field_val_s = (field_r == F_MIN) ? shadow_r[7:0] : shadow_r[15:8];
    end

    alarm_set_step u_step (
        .value   (field_val_s),
        .up      (step_up_s),
        .down    (step_dn_s),
        .is_hour (field_r == F_HOUR),
        .next    (field_next_s)
    );

    // Edit FSM with registered outputs, button history and repeat counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= S_IDLE;
            alarm_r   <= ALARM_INIT;
            shadow_r  <= ALARM_INIT;
            field_r   <= F_HOUR;
            editing_r <= 1'b0;
            changed_r <= 1'b0;
            u_hist_r  <= 1'b0;
            d_hist_r  <= 1'b0;
            l_hist_r  <= 1'b0;
            r_hist_r  <= 1'b0;
            c_hist_r  <= 1'b0;
            rep_cnt_r <= CNT_ZERO;
            rep_on_r  <= 1'b0;
        end else begin
            u_hist_r  <= push_u;
            d_hist_r  <= push_d;
            l_hist_r  <= push_l;
            r_hist_r  <= push_r;
            c_hist_r  <= push_c;
            changed_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    shadow_r  <= alarm_r;
                    rep_cnt_r <= CNT_ZERO;
                    rep_on_r  <= 1'b0;
                    if (SPDT_set) begin
                        state_r   <= S_EDIT;
                        editing_r <= 1'b1;
                        field_r   <= F_HOUR;
                    end else begin
                        state_r   <= S_IDLE;
                        editing_r <= 1'b0;
                    end
                end
                S_EDIT: begin
                    if (!SPDT_set) begin
                        state_r   <= S_IDLE;
                        editing_r <= 1'b0;
                        shadow_r  <= alarm_r;
                        rep_cnt_r <= CNT_ZERO;
                        rep_on_r  <= 1'b0;
                    end else if (c_rise_s) begin
                        state_r   <= S_COMMIT;
                        editing_r <= 1'b0;
                        alarm_r   <= shadow_r;
                        changed_r <= 1'b1;
                        rep_cnt_r <= CNT_ZERO;
                        rep_on_r  <= 1'b0;
                    end else if (field_evt_s) begin
                        field_r   <= r_rise_s ? F_MIN : F_HOUR;
                        rep_cnt_r <= CNT_ZERO;
                        rep_on_r  <= 1'b0;
                    end else begin
                        if (step_up_s || step_dn_s) begin
                            if (field_r == F_MIN) begin
                                shadow_r[7:0] <= field_next_s;
                            end else begin
                                shadow_r[15:8] <= field_next_s;
                            end
                        end
                        if (!(u_only_s || d_only_s)) begin
                            rep_cnt_r <= CNT_ZERO;
                            rep_on_r  <= 1'b0;
                        end else if (act_rise_s) begin
                            rep_cnt_r <= CNT_ONE;
                            rep_on_r  <= 1'b0;
                        end else if (rep_fire_s) begin
                            rep_cnt_r <= CNT_ONE;
                            rep_on_r  <= 1'b1;
                        end else if (rep_cnt_r != CNT_ZERO) begin
                            rep_cnt_r <= rep_cnt_r + CNT_ONE;
                        end else begin
                            rep_cnt_r <= CNT_ZERO;
                        end
                    end
                end
                S_COMMIT: begin
                    rep_cnt_r <= CNT_ZERO;
                    rep_on_r  <= 1'b0;
                    if (SPDT_set) begin
                        state_r   <= S_EDIT;
                        editing_r <= 1'b1;
                    end else begin
                        state_r   <= S_IDLE;
                        editing_r <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= S_IDLE;
                    editing_r <= 1'b0;
                    shadow_r  <= alarm_r;
                    rep_cnt_r <= CNT_ZERO;
                    rep_on_r  <= 1'b0;
                end
            endcase
        end
    end

    assign alarm         = alarm_r;
    assign edit_value    = shadow_r;
    assign edit_field    = field_r;
    assign editing       = editing_r;
    assign alarm_changed = changed_r;

endmodule

// File: tb/tb_alarm_set.sv
// Self-checking bench for alarm_set: a vector table plus model-driven sequences,
// all expectations flowing through a scoreboard queue.
module tb_alarm_set;

    logic        clk = 1'b0;
    logic        reset;
    logic        SPDT_set;
    logic        push_u;
    logic        push_d;
    logic        push_l;
    logic        push_r;
    logic        push_c;
    logic [15:0] alarm;
    logic [15:0] edit_value;
    logic        edit_field;
    logic        editing;
    logic        alarm_changed;

    alarm_set #(
        .ALARM_INIT   (16'h0700),
        .REPEAT_DELAY (5),
        .REPEAT_RATE  (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .SPDT_set      (SPDT_set),
        .push_u        (push_u),
        .push_d        (push_d),
        .push_l        (push_l),
        .push_r        (push_r),
        .push_c        (push_c),
        .alarm         (alarm),
        .edit_value    (edit_value),
        .edit_field    (edit_field),
        .editing       (editing),
        .alarm_changed (alarm_changed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] alarm;
        logic [15:0] ev;
        logic        field;
        logic        editing;
        logic        changed;
    } exp_t;

    typedef struct {
        logic set;
        logic u;
        logic d;
        logic l;
        logic r;
        logic c;
        exp_t e;
    } vec_t;

    exp_t        exp_q[$];
    vec_t        tbl[11];
    int          total = 0;
    int          bad = 0;
    logic [15:0] m_alarm;
    logic [15:0] m_sh;
    logic        m_field;

    function automatic exp_t mk(input logic [15:0] a, input logic [15:0] ev,
                                input logic f, input logic ed, input logic ch);
        exp_t e;
        e.alarm = a; e.ev = ev; e.field = f; e.editing = ed; e.changed = ch;
        return e;
    endfunction

    function automatic vec_t mv(input logic set, input logic u, input logic d, input logic l,
                                input logic r, input logic c, input exp_t e);
        vec_t v;
        v.set = set; v.u = u; v.d = d; v.l = l; v.r = r; v.c = c; v.e = e;
        return v;
    endfunction

    // Reference stepper via integer arithmetic
    function automatic logic [7:0] ref_step(input logic [7:0] v, input logic up, input logic hour);
        int n;
        int m;
        logic [3:0] t;
        logic [3:0] o;
        n = int'(v[7:4]) * 10 + int'(v[3:0]);
        m = hour ? 24 : 60;
        n = up ? (n + 1) % m : (n + m - 1) % m;
        t = 4'(n / 10);
        o = 4'(n % 10);
        return {t, o};
    endfunction

    task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", nm, act, want);
        end
    endtask

    task automatic check_outputs(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s scoreboard empty actual=0 expected=1", tag);
        end else begin
            e = exp_q.pop_front();
            cmp({tag, ".alarm"},   alarm,               e.alarm);
            cmp({tag, ".ev"},      edit_value,          e.ev);
            cmp({tag, ".field"},   {15'd0, edit_field}, {15'd0, e.field});
            cmp({tag, ".editing"}, {15'd0, editing},    {15'd0, e.editing});
            cmp({tag, ".changed"}, {15'd0, alarm_changed}, {15'd0, e.changed});
        end
    endtask

    task automatic drive(input string tag, input logic set, input logic u, input logic d,
                         input logic l, input logic r, input logic c, input exp_t e);
        SPDT_set = set; push_u = u; push_d = d; push_l = l; push_r = r; push_c = c;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic press(input string tag, input logic up);
        if (m_field) m_sh[7:0] = ref_step(m_sh[7:0], up, 1'b0);
        else m_sh[15:8] = ref_step(m_sh[15:8], up, 1'b1);
        drive(tag, 1'b1, up, !up, 1'b0, 1'b0, 1'b0, mk(m_alarm, m_sh, m_field, 1'b1, 1'b0));
        drive(tag, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(m_alarm, m_sh, m_field, 1'b1, 1'b0));
    endtask

    task automatic sel(input logic f);
        m_field = f;
        drive("sel", 1'b1, 1'b0, 1'b0, !f, f, 1'b0, mk(m_alarm, m_sh, m_field, 1'b1, 1'b0));
        drive("sel", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(m_alarm, m_sh, m_field, 1'b1, 1'b0));
    endtask

    task automatic commit();
        m_alarm = m_sh;
        drive("commit", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, mk(m_alarm, m_sh, m_field, 1'b0, 1'b1));
        drive("commit_after", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(m_alarm, m_sh, m_field, 1'b1, 1'b0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        // IDLE ignores buttons, field select (both-rise is a no-op), unchanged commit still pulses
        tbl[0]  = mv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mk(16'h0700, 16'h0700, 1'b0, 1'b0, 1'b0));
        tbl[1]  = mv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(16'h0700, 16'h0700, 1'b0, 1'b0, 1'b0));
        tbl[2]  = mv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(16'h0700, 16'h0700, 1'b0, 1'b1, 1'b0));
        tbl[3]  = mv(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, mk(16'h0700, 16'h0700, 1'b1, 1'b1, 1'b0));
        tbl[4]  = mv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(16'h0700, 16'h0700, 1'b1, 1'b1, 1'b0));
        tbl[5]  = mv(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, mk(16'h0700, 16'h0700, 1'b1, 1'b1, 1'b0));
        tbl[6]  = mv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(16'h0700, 16'h0700, 1'b1, 1'b1, 1'b0));
        tbl[7]  = mv(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, mk(16'h0700, 16'h0700, 1'b0, 1'b1, 1'b0));
        tbl[8]  = mv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(16'h0700, 16'h0700, 1'b0, 1'b1, 1'b0));
        tbl[9]  = mv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, mk(16'h0700, 16'h0700, 1'b0, 1'b0, 1'b1));
        tbl[10] = mv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(16'h0700, 16'h0700, 1'b0, 1'b1, 1'b0));

        reset = 1'b0; SPDT_set = 1'b0;
        push_u = 1'b0; push_d = 1'b0; push_l = 1'b0; push_r = 1'b0; push_c = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.push_back(mk(16'h0700, 16'h0700, 1'b0, 1'b0, 1'b0));
        check_outputs("reset");
        reset = 1'b1;

        for (int i = 0; i < 11; i++) begin
            drive($sformatf("vec%0d", i), tbl[i].set, tbl[i].u, tbl[i].d,
                  tbl[i].l, tbl[i].r, tbl[i].c, tbl[i].e);
        end

        m_alarm = 16'h0700; m_sh = 16'h0700; m_field = 1'b0;
        for (int i = 0; i < 17; i++) press("hour_up", 1'b1);
        cmp("hour_wrap17", edit_value, 16'h0000);
        commit();
        cmp("commit_0000", alarm, 16'h0000);

        for (int i = 0; i < 12; i++) press("hour_to12", 1'b1);
        sel(1'b1);
        press("min_dn", 1'b0);
        press("min_dn", 1'b0);
        cmp("at_1258", edit_value, 16'h1258);
        press("min_up", 1'b1);
        press("min_up", 1'b1);
        cmp("min_wrap_up", edit_value, 16'h1200);
        press("min_dn", 1'b0);
        cmp("min_wrap_dn", edit_value, 16'h1259);
        press("min_up", 1'b1);

        // Hold up for 12 cycles: steps at edge and cycles 5, 7, 9, 11
        for (int k = 0; k < 12; k++) begin
            if (k == 0 || k == 5 || k == 7 || k == 9 || k == 11)
                m_sh[7:0] = ref_step(m_sh[7:0], 1'b1, 1'b0);
            drive("hold", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mk(m_alarm, m_sh, m_field, 1'b1, 1'b0));
        end
        drive("hold_rel", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(m_alarm, m_sh, m_field, 1'b1, 1'b0));
        cmp("hold_total", edit_value, 16'h1205);
        for (int k = 0; k < 8; k++)
            drive("both", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, mk(m_alarm, m_sh, m_field, 1'b1, 1'b0));
        drive("both_rel", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(m_alarm, m_sh, m_field, 1'b1, 1'b0));

        sel(1'b0);
        for (int i = 0; i < 6; i++) press("hour_dn", 1'b0);
        sel(1'b1);
        for (int i = 0; i < 25; i++) press("min_up30", 1'b1);
        cmp("at_0630", edit_value, 16'h0630);
        commit();
        for (int i = 0; i < 15; i++) press("min_up45", 1'b1);
        cmp("at_0645", edit_value, 16'h0645);
        drive("drop", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(16'h0630, 16'h0630, 1'b1, 1'b0, 1'b0));
        drive("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(16'h0630, 16'h0630, 1'b1, 1'b0, 1'b0));

        // Async reset in the middle of a step cycle
        drive("reenter", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(16'h0630, 16'h0630, 1'b0, 1'b1, 1'b0));
        push_u = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        exp_q.push_back(mk(16'h0700, 16'h0700, 1'b0, 1'b0, 1'b0));
        check_outputs("async_rst");
        reset = 1'b1;
        #1;
        exp_q.push_back(mk(16'h0700, 16'h0700, 1'b0, 1'b0, 1'b0));
        check_outputs("rst_release");
        drive("post_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(16'h0700, 16'h0700, 1'b0, 1'b1, 1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
